// File: rtl/motor_driver_pkg.sv
// Shared encodings for the motor H-bridge driver and the main control FSM.
// State and command values must match on both sides of the mo/mp interface.
package motor_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_RUN  = 2'd2,
        ST_DEAD = 2'd3
    } state_t;

    localparam logic [1:0] MO_STOP = 2'b00;
    localparam logic [1:0] MO_A    = 2'b01;
    localparam logic [1:0] MO_B    = 2'b10;
    localparam logic [1:0] MO_BAD  = 2'b11;

    function automatic logic is_drive(input logic [1:0] c);
        return (c == MO_A) || (c == MO_B);
    endfunction

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM counter with a duty comparator.
// The pwm output is high while the counter is below the duty value.
module pwm_gen #(
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] i_duty,
    output logic                o_pwm
);

    logic [PWM_BITS-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_pwm = (r_cnt < i_duty);

endmodule

// File: rtl/motor_driver.sv
// H-bridge driver: soft-start ramp, dead time on stop/reverse, sticky fault.
// Leg outputs are registered and gated by the next state so DEAD is all-off.
module motor_driver
    import motor_driver_pkg::*;
#(
    parameter int PWM_BITS      = 4,
    parameter int RAMP_STEP_CYC = 16,
    parameter int DEAD_CYC      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mo,
    input  logic       mp,
    output logic       in1,
    output logic       in2,
    output logic       busy,
    output logic       fault
);

    localparam int SW = (RAMP_STEP_CYC > 1) ? $clog2(RAMP_STEP_CYC) : 1;
    localparam int DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
    localparam logic [SW-1:0]       STEP_LAST = SW'(RAMP_STEP_CYC - 1);
    localparam logic [DW-1:0]       DEAD_LOAD = DW'(DEAD_CYC - 1);

    state_t              r_state, w_state_nxt;
    logic [1:0]          r_dir, w_dir_nxt;
    logic [PWM_BITS-1:0] r_duty, w_duty_nxt;
    logic [SW-1:0]       r_step, w_step_nxt;
    logic [DW-1:0]       r_dead, w_dead_nxt;
    logic                r_in1, r_in2, r_fault;
    logic [1:0]          w_cmd;
    logic                w_pwm, w_drive, w_in1_nxt, w_in2_nxt;

    assign w_cmd = mp ? mo : MO_STOP;

    pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk    (clk),
        .reset  (reset),
        .i_duty (r_duty),
        .o_pwm  (w_pwm)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_dir   <= MO_STOP;
            r_duty  <= '0;
            r_step  <= '0;
            r_dead  <= '0;
            r_in1   <= 1'b0;
            r_in2   <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
            r_duty  <= w_duty_nxt;
            r_step  <= w_step_nxt;
            r_dead  <= w_dead_nxt;
            r_in1   <= w_in1_nxt;
            r_in2   <= w_in2_nxt;
            r_fault <= r_fault | (mp & (mo == MO_BAD));
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_duty_nxt  = r_duty;
        w_step_nxt  = r_step;
        w_dead_nxt  = r_dead;
        unique case (r_state)
            ST_IDLE: begin
                if (is_drive(w_cmd)) begin
                    w_state_nxt = ST_RAMP;
                    w_dir_nxt   = w_cmd;
                    w_duty_nxt  = '0;
                    w_step_nxt  = '0;
                end
            end
            ST_RAMP, ST_RUN: begin
                if (w_cmd != r_dir) begin
                    w_state_nxt = ST_DEAD;
                    w_dead_nxt  = DEAD_LOAD;
                    w_duty_nxt  = '0;
                    w_step_nxt  = '0;
                end else if (r_state == ST_RAMP) begin
                    if (r_step == STEP_LAST) begin
                        w_step_nxt = '0;
                        w_duty_nxt = r_duty + 1'b1;
                        if (r_duty == DUTY_MAX - 1'b1) begin
                            w_state_nxt = ST_RUN;
                        end
                    end else begin
                        w_step_nxt = r_step + 1'b1;
                    end
                end
            end
            ST_DEAD: begin
                // Only the command seen at expiry matters; changes never reload.
                if (r_dead == '0) begin
                    if (is_drive(w_cmd)) begin
                        w_state_nxt = ST_RAMP;
                        w_dir_nxt   = w_cmd;
                        w_duty_nxt  = '0;
                        w_step_nxt  = '0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_dead_nxt = r_dead - 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != ST_IDLE);
        w_drive   = (w_state_nxt == ST_RAMP) || (w_state_nxt == ST_RUN);
        w_in1_nxt = w_pwm & w_drive & (w_dir_nxt == MO_A);
        w_in2_nxt = w_pwm & w_drive & (w_dir_nxt == MO_B);
    end

    assign in1   = r_in1;
    assign in2   = r_in2;
    assign fault = r_fault;

endmodule

// File: tb/tb_motor_driver.sv
// Self-checking bench for motor_driver: vector table, directed corner
// sequences and randomized commands against an elapsed-time reference model.
module tb_motor_driver;

    localparam int PB     = 4;
    localparam int STEP   = 16;
    localparam int DC     = 4;
    localparam int PER    = 1 << PB;
    localparam int RAMP_T = (PER - 1) * STEP;

    localparam int P_IDLE = 0;
    localparam int P_RAMP = 1;
    localparam int P_RUN  = 2;
    localparam int P_DEAD = 3;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       mp    = 1'b0;
    logic [1:0] mo    = 2'b00;
    logic       in1, in2, busy, fault;

    motor_driver #(
        .PWM_BITS      (PB),
        .RAMP_STEP_CYC (STEP),
        .DEAD_CYC      (DC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mo    (mo),
        .mp    (mp),
        .in1   (in1),
        .in2   (in2),
        .busy  (busy),
        .fault (fault)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Model: phase plus edges elapsed in that phase.
    int         m_phase, m_t, m_dir, m_cnt;
    bit         m_fault;
    logic [3:0] m_out;

    typedef struct {
        logic [1:0] mo;
        logic       mp;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic int m_duty();
        if (m_phase == P_RAMP) return m_t / STEP;
        if (m_phase == P_RUN) return PER - 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE;
        m_t     = 0;
        m_dir   = 0;
        m_cnt   = 0;
        m_fault = 0;
        m_out   = 4'b0;
    endtask

    task automatic model_edge(input logic [1:0] vmo, input logic vmp);
        int cmd;
        bit go, pw, act;
        cmd = vmp ? int'(vmo) : 0;
        go  = (cmd == 1) || (cmd == 2);
        pw  = (m_cnt < m_duty());
        if (vmp && vmo == 2'b11) m_fault = 1;
        case (m_phase)
            P_IDLE: if (go) begin
                m_phase = P_RAMP; m_dir = cmd; m_t = 0;
            end
            P_RAMP, P_RUN: begin
                if (cmd != m_dir) begin
                    m_phase = P_DEAD; m_t = 0;
                end else if (m_phase == P_RAMP) begin
                    m_t++;
                    if (m_t == RAMP_T) m_phase = P_RUN;
                end
            end
            default: begin
                if (m_t == DC - 1) begin
                    if (go) begin
                        m_phase = P_RAMP; m_dir = cmd; m_t = 0;
                    end else begin
                        m_phase = P_IDLE;
                    end
                end else begin
                    m_t++;
                end
            end
        endcase
        m_cnt = (m_cnt + 1) % PER;
        act   = (m_phase == P_RAMP) || (m_phase == P_RUN);
        m_out = {pw && act && m_dir == 1, pw && act && m_dir == 2,
                 m_phase != P_IDLE, m_fault};
    endtask

    task automatic apply(input logic [1:0] vmo, input logic vmp,
                         input bit use_model);
        mo = vmo;
        mp = vmp;
        @(posedge clk);
        model_edge(vmo, vmp);
        #1;
        if (use_model) chk("model", {in1, in2, busy, fault}, m_out);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        mo    = 2'b00;
        mp    = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_out", {in1, in2, busy, fault}, 4'b0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int c1, c2, w1, w2, len;
        bit found;
        logic [1:0] rmo;
        logic rmp;

        tbl[0]  = '{2'b00, 1'b1, 4'b0000};
        tbl[1]  = '{2'b11, 1'b0, 4'b0000};
        tbl[2]  = '{2'b01, 1'b0, 4'b0000};
        tbl[3]  = '{2'b11, 1'b1, 4'b0001};
        tbl[4]  = '{2'b01, 1'b1, 4'b0011};
        tbl[5]  = '{2'b01, 1'b1, 4'b0011};
        tbl[6]  = '{2'b00, 1'b1, 4'b0011};
        tbl[7]  = '{2'b00, 1'b1, 4'b0011};
        tbl[8]  = '{2'b10, 1'b0, 4'b0011};
        tbl[9]  = '{2'b00, 1'b1, 4'b0011};
        tbl[10] = '{2'b00, 1'b1, 4'b0001};
        tbl[11] = '{2'b10, 1'b1, 4'b0011};

        model_reset();
        #12;
        chk("reset_hold", {in1, in2, busy, fault}, 4'b0);
        do_reset();

        for (int i = 0; i < 12; i++) begin
            apply(tbl[i].mo, tbl[i].mp, 1'b0);
            chk($sformatf("vec%0d", i), {in1, in2, busy, fault}, tbl[i].exp);
        end

        // Soft start from reset with direction A held.
        do_reset();
        c2 = 0; w1 = 0; w2 = 0;
        for (int k = 1; k <= 260; k++) begin
            apply(2'b01, 1'b1, 1'b1);
            if (k == 1) chk("soft_busy", busy, 1);
            if (in2) c2++;
            if (k >= 226 && k <= 241 && in1) w1++;
            if (k >= 242 && k <= 257 && in1) w2++;
        end
        chk("soft_in2_quiet", c2, 0);
        chk("soft_last_ramp_duty", w1, PER - 2);
        chk("soft_run_duty", w2, PER - 1);

        // Reversal from RUN.
        c1 = 0; c2 = 0;
        for (int k = 1; k <= 64; k++) begin
            apply(2'b10, 1'b1, 1'b1);
            if (k <= DC) chk("rev_all_off", {in1, in2, busy}, 3'b001);
            if (in1) c1++;
            if (in2) c2++;
        end
        chk("rev_in1_quiet", c1, 0);
        chk("rev_in2_pulses", c2 > 0, 1);

        // Stop by dropping mp in RUN.
        for (int k = 0; k < 250; k++) apply(2'b10, 1'b1, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            apply(2'b10, 1'b0, 1'b1);
            if (k == DC) chk("stop_dead_busy", busy, 1);
            if (k == DC + 1) chk("stop_idle", busy, 0);
        end

        // Illegal command during RAMP.
        for (int k = 0; k < 20; k++) apply(2'b01, 1'b1, 1'b1);
        apply(2'b11, 1'b1, 1'b1);
        chk("bad_fault", {busy, fault}, 2'b11);
        for (int k = 1; k <= DC; k++) apply(2'b00, 1'b1, 1'b1);
        chk("bad_idle_sticky", {busy, fault}, 2'b01);

        // Dead-time glitch: command wiggles inside DEAD.
        do_reset();
        for (int k = 0; k < 260; k++) apply(2'b01, 1'b1, 1'b1);
        apply(2'b00, 1'b1, 1'b1);
        apply(2'b01, 1'b1, 1'b1);
        apply(2'b00, 1'b1, 1'b1);
        apply(2'b10, 1'b1, 1'b1);
        chk("glitch_dead", {in1, in2, busy}, 3'b001);
        c1 = 0; c2 = 0;
        for (int k = 0; k < 48; k++) begin
            apply(2'b10, 1'b1, 1'b1);
            if (in1) c1++;
            if (in2) c2++;
        end
        chk("glitch_in1_quiet", c1, 0);
        chk("glitch_in2_pulses", c2 > 0, 1);

        // Asynchronous reset in RUN while in1 is high.
        do_reset();
        apply(2'b11, 1'b1, 1'b1);
        for (int k = 0; k < 260; k++) apply(2'b01, 1'b1, 1'b1);
        found = 0;
        for (int k = 0; k < 2 * PER && !found; k++) begin
            if (in1) found = 1;
            else apply(2'b01, 1'b1, 1'b1);
        end
        chk("async_found_pulse", found, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_in1_low", {in1, in2, busy}, 3'b000);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        mo = 2'b00;
        #1;
        chk("async_after", {busy, fault}, 2'b00);

        // Randomized command bursts.
        for (int blk = 0; blk < 40; blk++) begin
            rmo = 2'($urandom_range(0, 3));
            if (rmo == 2'b11 && $urandom_range(0, 7) != 0) rmo = 2'b01;
            rmp = ($urandom_range(0, 9) < 8);
            len = $urandom_range(1, 300);
            for (int k = 0; k < len; k++) apply(rmo, rmp, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
